// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for sdram_port_arbiter: two requester ports plus the SDRAM controller side.
// slave = arbiter view, master = requesters/controller view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [15:0]       p0_wdata;
  logic              p0_ack;
  logic [15:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [15:0]       p1_wdata;
  logic              p1_ack;
  logic [15:0]       p1_rdata;

  logic              ctrl_req;
  logic              ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [15:0]       ctrl_wdata;
  logic              ctrl_ack;
  logic [15:0]       ctrl_rdata;
  logic              ctrl_ref_req;
  logic              ctrl_ref_ack;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_ref_req,
    input  ctrl_ack, ctrl_rdata, ctrl_ref_ack
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_ref_req,
    output ctrl_ack, ctrl_rdata, ctrl_ref_ack
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-word SDRAM controller, owning auto-refresh.
// Optional watchdog on controller acks enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int REF_PERIOD  = 390,
  parameter int PEND_MAX    = 7,
  parameter int URGENT_PEND = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  sdram_port_arbiter_if.slave  bus,
  output logic [1:0]           grant,
  output logic [2:0]           ref_pending,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, REF, DONE} state_t;

  localparam int               TMR_W    = $clog2(REF_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);
  localparam logic [2:0]       PEND_SAT = 3'(PEND_MAX);
  localparam logic [2:0]       PEND_URG = 3'(URGENT_PEND);
  localparam int               WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_t            state;
  logic [TMR_W-1:0]  ref_timer;
  logic [WD_W-1:0]   wdog;
  logic              rr_ptr;
  logic              tick_wrap;
  logic              wd_fire;
  logic              ref_done;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  // Tie goes to the port that did not win last time.
  always_comb begin
    sel_port = 1'b0;
    if (bus.p0_req && bus.p1_req) sel_port = ~rr_ptr;
    else if (bus.p1_req)          sel_port = 1'b1;
    sel_we    = sel_port ? bus.p1_we    : bus.p0_we;
    sel_addr  = sel_port ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = sel_port ? bus.p1_wdata : bus.p0_wdata;
  end

  // Watchdog only fires when the awaited ack is absent in that same cycle.
  always_comb begin
    tick_wrap = (ref_timer == TMR_LAST);
    wd_fire   = 1'b0;
    if (WD_EN && wdog == WD_LAST) begin
      if ((state == GNT0 || state == GNT1) && !bus.ctrl_ack) wd_fire = 1'b1;
      if (state == REF && !bus.ctrl_ref_ack)                 wd_fire = 1'b1;
    end
    ref_done = (state == REF) && (bus.ctrl_ref_ack || wd_fire);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= IDLE;
      ref_timer        <= '0;
      wdog             <= '0;
      rr_ptr           <= 1'b1;
      ref_pending      <= '0;
      grant            <= '0;
      timeout_err      <= 1'b0;
      bus.ctrl_req     <= 1'b0;
      bus.ctrl_we      <= 1'b0;
      bus.ctrl_addr    <= '0;
      bus.ctrl_wdata   <= '0;
      bus.ctrl_ref_req <= 1'b0;
      bus.p0_ack       <= 1'b0;
      bus.p1_ack       <= 1'b0;
      bus.p0_rdata     <= '0;
      bus.p1_rdata     <= '0;
    end else begin
      ref_timer <= tick_wrap ? '0 : ref_timer + 1'b1;

      // A wrap coinciding with a completed refresh cancels out.
      if (tick_wrap && !ref_done) begin
        if (ref_pending != PEND_SAT) ref_pending <= ref_pending + 1'b1;
      end else if (ref_done && !tick_wrap) begin
        ref_pending <= ref_pending - 1'b1;
      end

      wdog <= (state == IDLE || state == DONE) ? '0 : wdog + 1'b1;

      unique case (state)
        IDLE: begin
          if (ref_pending >= PEND_URG) begin
            state            <= REF;
            bus.ctrl_ref_req <= 1'b1;
          end else if (bus.p0_req || bus.p1_req) begin
            state          <= sel_port ? GNT1 : GNT0;
            grant          <= sel_port ? 2'b10 : 2'b01;
            rr_ptr         <= sel_port;
            bus.ctrl_req   <= 1'b1;
            bus.ctrl_we    <= sel_we;
            bus.ctrl_addr  <= sel_addr;
            bus.ctrl_wdata <= sel_wdata;
          end else if (ref_pending != '0) begin
            state            <= REF;
            bus.ctrl_ref_req <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (bus.ctrl_ack || wd_fire) begin
            state        <= DONE;
            bus.ctrl_req <= 1'b0;
            if (state == GNT0) begin
              bus.p0_ack <= 1'b1;
              if (wd_fire)           bus.p0_rdata <= 16'hDEAD;
              else if (!bus.ctrl_we) bus.p0_rdata <= bus.ctrl_rdata;
            end else begin
              bus.p1_ack <= 1'b1;
              if (wd_fire)           bus.p1_rdata <= 16'hDEAD;
              else if (!bus.ctrl_we) bus.p1_rdata <= bus.ctrl_rdata;
            end
            if (wd_fire) timeout_err <= 1'b1;
          end
        end
        REF: begin
          if (ref_done) begin
            state            <= IDLE;
            bus.ctrl_ref_req <= 1'b0;
            if (wd_fire) timeout_err <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          grant      <= '0;
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (REF_PERIOD = 390, URGENT_PEND = 4, PEND_MAX = 7).
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] grant;
  logic [2:0] ref_pending;
  logic       timeout_err;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sdram_port_arbiter_if #(.ADDR_W(24)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(24), .REF_PERIOD(390), .PEND_MAX(7), .URGENT_PEND(4), .TIMEOUT(1023)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus),
    .grant(grant), .ref_pending(ref_pending), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.ctrl_ack = 0; bus.ctrl_rdata = '0; bus.ctrl_ref_ack = 0;
    sys_rst = 1;
    tick(); tick();
    sys_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.ctrl_req, bus.ctrl_we, bus.ctrl_ref_req, bus.p0_ack, bus.p1_ack, timeout_err, grant, ref_pending} !== 11'd0)
      $display("FAIL reset_ctrl: got %b want 0", {bus.ctrl_req, bus.ctrl_we, bus.ctrl_ref_req, bus.p0_ack, bus.p1_ack, timeout_err, grant, ref_pending});
    else n_pass++;
    n_checks++;
    if ({bus.p0_rdata, bus.p1_rdata, bus.ctrl_wdata, bus.ctrl_addr} !== 72'd0)
      $display("FAIL reset_data: got %h want 0", {bus.p0_rdata, bus.p1_rdata, bus.ctrl_wdata, bus.ctrl_addr});
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({bus.ctrl_req, bus.ctrl_ref_req, grant} !== 4'd0)
      $display("FAIL reset_idle: got %b want 0", {bus.ctrl_req, bus.ctrl_ref_req, grant});
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000123;
    tick();
    n_checks++;
    if ({bus.ctrl_req, bus.ctrl_we, grant} !== 4'b1001)
      $display("FAIL rd_grant: got req/we/grant %b want 1001", {bus.ctrl_req, bus.ctrl_we, grant});
    else n_pass++;
    n_checks++;
    if (bus.ctrl_addr !== 24'h000123) $display("FAIL rd_addr: got %h want 000123", bus.ctrl_addr);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if ({bus.ctrl_req, bus.p0_ack} !== 2'b10)
      $display("FAIL rd_wait: got req/ack %b want 10", {bus.ctrl_req, bus.p0_ack});
    else n_pass++;
    bus.ctrl_ack = 1; bus.ctrl_rdata = 16'hBEEF;
    tick();
    bus.ctrl_ack = 0; bus.ctrl_rdata = 16'h0000;
    n_checks++;
    if ({bus.p0_ack, bus.ctrl_req, bus.p1_ack} !== 3'b100)
      $display("FAIL rd_ack: got ack/req/p1ack %b want 100", {bus.p0_ack, bus.ctrl_req, bus.p1_ack});
    else n_pass++;
    n_checks++;
    if (bus.p0_rdata !== 16'hBEEF) $display("FAIL rd_data: got %h want BEEF", bus.p0_rdata);
    else n_pass++;
    bus.p0_req = 0;
    tick();
    n_checks++;
    if ({bus.p0_ack, grant} !== 3'b000)
      $display("FAIL rd_done: got ack/grant %b want 000", {bus.p0_ack, grant});
    else n_pass++;
    n_checks++;
    if (bus.p0_rdata !== 16'hBEEF) $display("FAIL rd_hold: got %h want BEEF", bus.p0_rdata);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [15:0] exp_d;
    int w;
    do_reset();
    bus.p0_we = 1; bus.p0_addr = 24'h000010; bus.p0_wdata = 16'h1111;
    bus.p1_we = 1; bus.p1_addr = 24'h000020; bus.p1_wdata = 16'h2222;
    bus.p0_req = 1; bus.p1_req = 1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (k % 2 == 0) ? 16'h1111 : 16'h2222;
      w = 0;
      while (bus.ctrl_req !== 1'b1 && w < 20) begin tick(); w++; end
      n_checks++;
      if (grant !== exp_g) $display("FAIL rr_grant%0d: got %b want %b", k, grant, exp_g);
      else n_pass++;
      n_checks++;
      if ({bus.ctrl_we, bus.ctrl_wdata} !== {1'b1, exp_d})
        $display("FAIL rr_wdata%0d: got we/data %b/%h want 1/%h", k, bus.ctrl_we, bus.ctrl_wdata, exp_d);
      else n_pass++;
      bus.ctrl_ack = 1;
      tick();
      bus.ctrl_ack = 0;
      n_checks++;
      if ({bus.p1_ack, bus.p0_ack} !== exp_g)
        $display("FAIL rr_ack%0d: got %b want %b", k, {bus.p1_ack, bus.p0_ack}, exp_g);
      else n_pass++;
      if (exp_g == 2'b01) bus.p0_req = 0; else bus.p1_req = 0;
      tick();
      bus.p0_req = 1; bus.p1_req = 1;
    end
    bus.p0_req = 0; bus.p1_req = 0;
  endtask

  task automatic test_refresh();
    do_reset();
    bus.ctrl_ack = 1; bus.ctrl_ref_ack = 1;
    tick();
    bus.ctrl_ack = 0; bus.ctrl_ref_ack = 0;
    repeat (388) tick();
    n_checks++;
    if ({bus.p0_ack, bus.p1_ack, ref_pending} !== 5'd0)
      $display("FAIL ref_before: got acks/pending %b want 0", {bus.p0_ack, bus.p1_ack, ref_pending});
    else n_pass++;
    tick();
    n_checks++;
    if ({ref_pending, bus.ctrl_ref_req} !== {3'd1, 1'b0})
      $display("FAIL ref_tick: got pending %0d ref_req %b want 1 0", ref_pending, bus.ctrl_ref_req);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ctrl_ref_req !== 1'b1) $display("FAIL ref_req: got %b want 1", bus.ctrl_ref_req);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ctrl_ref_req, ref_pending} !== {1'b1, 3'd1})
      $display("FAIL ref_hold: got req %b pending %0d want 1 1", bus.ctrl_ref_req, ref_pending);
    else n_pass++;
    bus.ctrl_ref_ack = 1;
    tick();
    bus.ctrl_ref_ack = 0;
    n_checks++;
    if ({bus.ctrl_ref_req, ref_pending} !== 4'd0)
      $display("FAIL ref_ack: got req %b pending %0d want 0 0", bus.ctrl_ref_req, ref_pending);
    else n_pass++;
    repeat (386) tick();
    n_checks++;
    if (ref_pending !== 3'd0) $display("FAIL ref_gap: got %0d want 0", ref_pending);
    else n_pass++;
    tick();
    n_checks++;
    if (ref_pending !== 3'd1) $display("FAIL ref_tick2: got %0d want 1", ref_pending);
    else n_pass++;
    tick();
    bus.ctrl_ref_ack = 1;
    tick();
    bus.ctrl_ref_ack = 0;
    n_checks++;
    if ({bus.ctrl_ref_req, ref_pending} !== 4'd0)
      $display("FAIL ref_ack2: got req %b pending %0d want 0 0", bus.ctrl_ref_req, ref_pending);
    else n_pass++;
  endtask

  task automatic test_urgent();
    int w;
    do_reset();
    w = 0;
    while (ref_pending !== 3'd5 && w < 2500) begin tick(); w++; end
    n_checks++;
    if ({ref_pending, bus.ctrl_ref_req} !== {3'd5, 1'b1})
      $display("FAIL urg_stall: got pending %0d ref_req %b want 5 1", ref_pending, bus.ctrl_ref_req);
    else n_pass++;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 24'h000777;
    bus.ctrl_ref_ack = 1;
    tick();
    bus.ctrl_ref_ack = 0;
    n_checks++;
    if (ref_pending !== 3'd4) $display("FAIL urg_dec: got %0d want 4", ref_pending);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ctrl_ref_req, bus.ctrl_req, grant} !== 4'b1000)
      $display("FAIL urg_pref: got ref_req/req/grant %b want 1000", {bus.ctrl_ref_req, bus.ctrl_req, grant});
    else n_pass++;
    bus.ctrl_ref_ack = 1;
    tick();
    bus.ctrl_ref_ack = 0;
    tick();
    n_checks++;
    if ({bus.ctrl_ref_req, bus.ctrl_req, grant, ref_pending} !== {4'b0110, 3'd3})
      $display("FAIL urg_port: got ref_req/req/grant %b pending %0d want 0110 3",
               {bus.ctrl_ref_req, bus.ctrl_req, grant}, ref_pending);
    else n_pass++;
    bus.ctrl_ack = 1;
    tick();
    bus.ctrl_ack = 0;
    bus.p1_req = 0;
    n_checks++;
    if (bus.p1_ack !== 1'b1) $display("FAIL urg_p1ack: got %b want 1", bus.p1_ack);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (bus.ctrl_ref_req !== 1'b1) $display("FAIL urg_ref_low: got %b want 1", bus.ctrl_ref_req);
    else n_pass++;
    repeat (2400) tick();
    n_checks++;
    if ({ref_pending, bus.ctrl_ref_req} !== {3'd7, 1'b1})
      $display("FAIL urg_sat: got pending %0d ref_req %b want 7 1", ref_pending, bus.ctrl_ref_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 24'hABCDEF;
    tick();
    n_checks++;
    if ({grant, bus.ctrl_req} !== 3'b101)
      $display("FAIL rst_mid_grant: got grant/req %b want 101", {grant, bus.ctrl_req});
    else n_pass++;
    tick();
    sys_rst = 1; bus.p1_req = 0; bus.ctrl_ack = 1; bus.ctrl_rdata = 16'h5555;
    tick();
    sys_rst = 0; bus.ctrl_ack = 0;
    n_checks++;
    if ({bus.ctrl_req, bus.ctrl_we, bus.ctrl_ref_req, bus.p0_ack, bus.p1_ack, timeout_err, grant, ref_pending} !== 11'd0)
      $display("FAIL rst_mid_ctrl: got %b want 0", {bus.ctrl_req, bus.ctrl_we, bus.ctrl_ref_req, bus.p0_ack, bus.p1_ack, timeout_err, grant, ref_pending});
    else n_pass++;
    n_checks++;
    if ({bus.p0_rdata, bus.p1_rdata, bus.ctrl_wdata, bus.ctrl_addr} !== 72'd0)
      $display("FAIL rst_mid_data: got %h want 0", {bus.p0_rdata, bus.p1_rdata, bus.ctrl_wdata, bus.ctrl_addr});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.p1_ack, bus.ctrl_req, grant} !== 4'd0)
      $display("FAIL rst_mid_after: got ack/req/grant %b want 0", {bus.p1_ack, bus.ctrl_req, grant});
    else n_pass++;
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000042;
    tick();
    repeat (1022) tick();
    n_checks++;
    if ({bus.ctrl_req, timeout_err, bus.p0_ack} !== 3'b100)
      $display("FAIL to_wait: got req/err/ack %b want 100", {bus.ctrl_req, timeout_err, bus.p0_ack});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.ctrl_req, timeout_err, bus.p0_ack} !== 3'b011)
      $display("FAIL to_fire: got req/err/ack %b want 011", {bus.ctrl_req, timeout_err, bus.p0_ack});
    else n_pass++;
    n_checks++;
    if (bus.p0_rdata !== 16'hDEAD) $display("FAIL to_data: got %h want DEAD", bus.p0_rdata);
    else n_pass++;
    bus.p0_req = 0;
    repeat (4) tick();
    n_checks++;
    if ({timeout_err, bus.p0_ack} !== 2'b10)
      $display("FAIL to_sticky: got err/ack %b want 10", {timeout_err, bus.p0_ack});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_refresh();
    test_urgent();
    test_reset_mid();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one single-word SDRAM controller port between two requesters: port 0 (UART MCU bus) and port 1 (secondary master, e.g. DMA/display).
- Owns the auto-refresh schedule. Refresh requests come from an internal interval timer and are kept as a saturating pending count.
- Sits between the MCU-side bus logic and the SDRAM command controller.
- Works on 16-bit words with a 24-bit word address (bank 2 + row 13 + col 9).

Parameters:
ADDR_W, 24, word address width on all ports
REF_PERIOD, 390, sys_clk cycles per refresh tick (7.8 us at 50 MHz)
PEND_MAX, 7, saturation value of pending-refresh count (3-bit counter)
URGENT_PEND, 4, pending count at or above which refresh preempts port grants
TIMEOUT, 1023, cycles to wait for ctrl_ack/ctrl_ref_ack (only with SDRAM_ARB_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock, single clock domain
sys_rst  in  1  synchronous reset, active-high
p0_req  in  1  port 0 access request, held until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  16  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  16  read data, valid with p0_ack and held until next ack
p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rdata  same as port 0, for port 1
ctrl_req  out  1  access request to SDRAM controller
ctrl_we  out  1  write/read to controller
ctrl_addr  out  ADDR_W  address to controller
ctrl_wdata  out  16  write data to controller
ctrl_ack  in  1  controller done pulse; ctrl_rdata valid in the same cycle
ctrl_rdata  in  16  controller read data
ctrl_ref_req  out  1  auto-refresh request
ctrl_ref_ack  in  1  refresh done pulse
grant  out  2  debug: 01 = port 0, 10 = port 1, 00 = none or refresh
ref_pending  out  3  debug: pending refresh count
timeout_err  out  1  sticky error flag (constant 0 without the macro)

Behaviour:
- Reset values: all outputs 0 (p0_rdata, p1_rdata, ctrl_addr, ctrl_wdata included). FSM = IDLE, timer = 0, pending = 0, round-robin pointer = port 1, so port 0 wins the first tie.
- Reset mid-operation: the in-flight request is abandoned without an ack. The SDRAM controller shares sys_rst.

Refresh timer:
- Counts 0..REF_PERIOD-1 and wraps.
- On wrap, pending increments and saturates at PEND_MAX.
- If a wrap and a ctrl_ref_ack occur in the same cycle, pending is unchanged.

FSM states: IDLE, GNT0, GNT1, REF, DONE.

IDLE priority, evaluated each cycle, first match wins:
1. pending >= URGENT_PEND -> REF.
2. Both ports requesting -> grant the port not equal to the pointer.
3. A single port requesting -> grant it.
4. pending > 0 -> REF.
5. Otherwise stay in IDLE.

Grant cycle:
- On the grant edge, register ctrl_we/addr/wdata from the winning port.
- Set ctrl_req = 1 and grant; update the pointer to the winner.

GNTx:
- ctrl_req stays 1 until the cycle ctrl_ack is seen.
- On that edge: ctrl_req <= 0, px_rdata <= ctrl_rdata (reads only; writes leave rdata unchanged), px_ack <= 1, state -> DONE.

DONE:
- px_ack is high for exactly this cycle; grant <= 00; state -> IDLE.
- A requester must drop req on the edge where it sees ack. Its req is therefore low in the following IDLE.

REF:
- ctrl_ref_req = 1 until ctrl_ref_ack; then ctrl_ref_req <= 0, pending decrements, state -> IDLE.

Latency:
- Request seen in IDLE at cycle N -> ctrl_req high at N+1.
- ctrl_ack at cycle M -> px_ack at M+1 -> IDLE at M+2 -> next grant visible at M+3.

Rules and boundaries:
- ctrl_ack outside GNTx and ctrl_ref_ack outside REF are ignored.
- Port requests arriving while busy wait; they are never dropped.
- Minimum port access turnaround: 3 cycles plus controller latency.

Optional Feature:
SDRAM_ARB_TIMEOUT_EN
- Defined: a watchdog counter runs in GNTx/REF and clears on entry.
  - If it reaches TIMEOUT without an ack, set timeout_err (sticky until sys_rst) and drop ctrl_req/ctrl_ref_req.
  - From GNTx: pulse px_ack with px_rdata = 16'hDEAD, via DONE.
  - From REF: decrement pending as if acked.
- Not defined: no watchdog; the FSM waits indefinitely; timeout_err tied 0.

Test Plan:
1. Reset, then p0 read addr 0x000123; controller acks 5 cycles after ctrl_req with rdata 0xBEEF -> ctrl_addr = 0x000123, ctrl_we = 0, p0_ack a single pulse one cycle after ctrl_ack, p0_rdata = 0xBEEF.
2. p0 and p1 request in the same cycle, both re-requesting continuously (writes 0x1111/0x2222) -> grant order p0, p1, p0, p1; ctrl_wdata matches the granted port each time.
3. No port traffic for 2*REF_PERIOD cycles, ctrl_ref_ack withheld for 1 cycle -> ref_pending reaches 1 at cycle 390; ctrl_ref_req asserts next cycle; pending returns to 0 after the ack.
4. Hold ctrl_ref_ack low until pending = 4, with p1 requesting continuously -> REF is chosen over p1 until pending < 4; pending never exceeds 7 under a longer stall.
5. Assert sys_rst for 1 cycle during GNT1 -> next cycle all outputs 0, no p1_ack, grant = 00, pending = 0.
6. (SDRAM_ARB_TIMEOUT_EN) p0 read, ctrl_ack never arrives -> after 1023 cycles ctrl_req = 0, p0_ack pulse with 0xDEAD, timeout_err = 1 and stays 1.
